mac4_dot_accumulator: RTL and testbench
=======================================

# mac4_dot_accumulator

Sequential dot-product stage sitting directly downstream of the 4x4 array multiplier. Accepts a stream of unsigned 4-bit operand pairs over a valid/ready handshake and registers each 8-bit product. Accumulates LEN consecutive products into a saturating sum, then presents the sum on a valid/ready output port with full backpressure.

## Interface
- LEN, default 4: terms per dot product, legal range 1..255.
- ACC_W, default 16: accumulator and result width, legal range 8..32.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low, synchronous deassert assumed upstream.
- clear  in  1  synchronous flush of the in-flight group and of any pending result.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair this cycle.
- in_a  in  4  unsigned multiplicand.
- in_b  in  4  unsigned multiplier.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  ACC_W  saturated dot product of the group.
- out_ovf  out  1  group saturated at least once.

## Operation
- Stage P (product register): on in_valid && in_ready, capture p_q = in_a*in_b (full 8-bit, zero-extended) and set p_valid.
- Stage A (accumulate): when p_valid and A can consume, acc <= sat(acc + p_q) and cnt <= cnt+1.
- sat(): if the true sum exceeds 2^ACC_W-1, the result is 2^ACC_W-1 and the sticky ovf flag for the group is set.
- Last term (cnt == LEN-1): load out_sum/out_ovf from the final sum and flag, set out_valid, and zero acc, cnt, and ovf in the same edge.
- A can consume unless the product is a last term and out_valid && !out_ready.
- p_valid clears when consumed with no new accept; it reloads when consumed with a simultaneous accept.
- in_ready = !p_valid || A consumes this cycle (combinational, no dependency on in_valid).
- Output hold: out_sum, out_ovf, and out_valid are stable while out_valid && !out_ready. out_valid clears on out_ready unless a new last term loads the same edge; in that case the register is overwritten and out_valid stays high.
- clear: at the edge, p_valid, acc, cnt, ovf, and out_valid go to 0. Any handshake in that cycle is ignored, and in_ready is 0 while clear is high.
- Reset: all of the above go to 0 immediately on rst_n low. out_sum and out_ovf reset to 0. A mid-group reset discards the partial sum.

## Timing
- Reset values: in_ready 1 (after reset release), out_valid 0, out_sum 0, out_ovf 0.
- Latency: last pair accepted at edge k, product at k, out_valid high after edge k+1. That is 2 cycles from acceptance to result.
- Throughput: 1 pair per cycle sustained while out_ready is held high, with no bubbles between groups.
- Backpressure: with out_valid held and out_ready low, in_ready falls only when the next last-term product is waiting in P. At most one further pair is absorbed (held in P).
- in_ready and out_valid never depend combinationally on in_valid. in_ready depends on out_ready.

## Structure
- Shared package mac4_pkg: constants OP_W=4 and PROD_W=8, and the function sat_add(acc, prod, ACC_W), which returns the sum plus an overflow bit.
- Sub-module: array_multiplier_4x4 provides the product. The bench checks it against in_a*in_b for all 256 pairs. P registers its output, with no additional pipeline inside the multiplier.
- cnt width is $clog2(LEN+1), and LEN=1 must work (every term is a last term).

## Test plan
- LEN=4, ACC_W=16, out_ready=1, pairs (15,15)x4 back-to-back: out_sum=900 and out_ovf=0, with out_valid exactly 2 cycles after the 4th acceptance. The next group of (1,2)x4 gives 8 with no idle cycle.
- LEN=4, ACC_W=8, pairs (15,15),(15,15),(1,1),(0,0): out_sum=255 and out_ovf=1. The next group of (2,3)x4 gives 24 with ovf=0.
- Backpressure, LEN=2, out_ready=0, 5 pairs (1,1) offered: the first result 2 holds stable. After the 3rd and 4th pairs, in_ready drops with the 4th pair parked in P. Raising out_ready delivers 2 then 2 in order, with no loss or duplication.
- Simultaneous events, LEN=1, out_ready=1 with continuous pairs (3,k): out_valid stays high and out_sum tracks 3k every cycle.
- Mid-group rst_n pulse after 2 of 4 pairs (7,7): outputs go to 0 immediately. A subsequent (1,1)x4 gives 4, not 102.
- clear asserted while a result is pending and P is full: out_valid drops and in_ready=0 during clear. The next group computes from zero.

Source files
------------

// File: rtl/mac4_dot_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// mac4_pkg
// Shared constants and helpers for the 4-bit MAC dot-product slice.
//   OP_W      : operand width of the multiplier inputs
//   PROD_W    : full product width
//   MAX_ACC_W : widest accumulator the helper supports
//   sat_add() : saturating add of a product onto an accumulator, returns
//               {overflow, saturated_sum} in a MAX_ACC_W+1 bit vector
// -----------------------------------------------------------------------------
package mac4_pkg;

  localparam int OP_W      = 4;
  localparam int PROD_W    = 8;
  localparam int MAX_ACC_W = 32;

  // The accumulator width is a runtime argument so one function serves every
  // ACC_W; callers keep the low acc_w bits of the result plus the top bit.
  function automatic logic [MAX_ACC_W:0] sat_add(
    input logic [MAX_ACC_W-1:0] acc,
    input logic [PROD_W-1:0]    prod,
    input int unsigned          acc_w
  );
    logic [MAX_ACC_W:0] sum;
    logic [MAX_ACC_W:0] max_v;
    sum   = {1'b0, acc} + {{(MAX_ACC_W + 1 - PROD_W){1'b0}}, prod};
    max_v = (33'd1 << acc_w) - 33'd1;
    if (sum > max_v) begin
      sat_add = {1'b1, max_v[MAX_ACC_W-1:0]};
    end else begin
      sat_add = {1'b0, sum[MAX_ACC_W-1:0]};
    end
  endfunction

endpackage

// File: rtl/mac4_dot_accumulator_mult.sv
// -----------------------------------------------------------------------------
// array_multiplier_4x4
// Purely combinational unsigned 4x4 array multiplier (no pipeline stage).
//   i_a    : multiplicand, OP_W bits
//   i_b    : multiplier,   OP_W bits
//   o_prod : full PROD_W-bit product
// -----------------------------------------------------------------------------
module array_multiplier_4x4
  import mac4_pkg::*;
(
  input  logic [OP_W-1:0]   i_a,
  input  logic [OP_W-1:0]   i_b,
  output logic [PROD_W-1:0] o_prod
);

  logic [PROD_W-1:0] w_pp [OP_W];

  // Partial-product rows: row i is i_a shifted by i, gated by bit i of i_b.
  always_comb begin
    for (int i = 0; i < OP_W; i++) begin
      if (i_b[i]) begin
        w_pp[i] = PROD_W'(i_a) << i;
      end else begin
        w_pp[i] = '0;
      end
    end
  end

  // Row summation of the partial products.
  always_comb begin
    o_prod = '0;
    for (int i = 0; i < OP_W; i++) begin
      o_prod = o_prod + w_pp[i];
    end
  end

endmodule

// File: rtl/mac4_dot_accumulator.sv
// -----------------------------------------------------------------------------
// mac4_dot_accumulator
// Streams unsigned 4-bit operand pairs, registers each product (stage P),
// accumulates LEN products with saturation (stage A) and presents the group
// sum on a valid/ready output with full backpressure.
//   clk, rst_n          : clock, async active-low reset
//   clear               : synchronous flush of in-flight group and result
//   in_valid/in_ready   : input handshake; in_a, in_b operands
//   out_valid/out_ready : output handshake; out_sum, out_ovf result
// -----------------------------------------------------------------------------
module mac4_dot_accumulator
  import mac4_pkg::*;
#(
  parameter int LEN   = 4,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  logic [PROD_W-1:0]  w_prod;
  logic [PROD_W-1:0]  r_p;
  logic               r_p_valid;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic               r_out_valid;
  logic [ACC_W-1:0]   r_out_sum;
  logic               r_out_ovf;

  logic               w_last;
  logic               w_consume;
  logic               w_accept;
  logic [MAX_ACC_W:0] w_sat;
  logic [ACC_W-1:0]   w_sum;
  logic               w_sum_ovf;
  logic               w_unused_sat;

  array_multiplier_4x4 u_mult (
    .i_a    (in_a),
    .i_b    (in_b),
    .o_prod (w_prod)
  );

  // Stage A only stalls when a last term would overwrite a result nobody took.
  assign w_last    = (r_cnt == LAST_CNT);
  assign w_consume = r_p_valid && !clear && !(w_last && r_out_valid && !out_ready);
  assign in_ready  = !clear && (!r_p_valid || w_consume);
  assign w_accept  = in_valid && in_ready;

  // Saturating sum of the held product onto the running accumulator.
  always_comb begin
    w_sat        = sat_add(MAX_ACC_W'(r_acc), r_p, ACC_W);
    w_sum        = w_sat[ACC_W-1:0];
    w_sum_ovf    = w_sat[MAX_ACC_W];
    w_unused_sat = ^w_sat;
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_ovf   = r_out_ovf;

  // Product register, accumulator, term counter and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p         <= '0;
      r_p_valid   <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (clear) begin
      r_p_valid   <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      // A consume with a simultaneous accept reloads P instead of emptying it.
      if (w_accept) begin
        r_p       <= w_prod;
        r_p_valid <= 1'b1;
      end else if (w_consume) begin
        r_p_valid <= 1'b0;
      end

      if (w_consume && w_last) begin
        // New result overwrites the output even if the old one is leaving now.
        r_out_sum   <= w_sum;
        r_out_ovf   <= r_ovf | w_sum_ovf;
        r_out_valid <= 1'b1;
        r_acc       <= '0;
        r_cnt       <= '0;
        r_ovf       <= 1'b0;
      end else begin
        if (w_consume) begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + CNT_W'(1);
          r_ovf <= r_ovf | w_sum_ovf;
        end
        if (r_out_valid && out_ready) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac4_dot_accumulator.sv
// -----------------------------------------------------------------------------
// tb_mac4_dot_accumulator
// Directed bench for mac4_dot_accumulator. Four instances cover the parameter
// sets used by the scenarios: u0 (LEN=4, ACC_W=16), u1 (LEN=4, ACC_W=8),
// u2 (LEN=2, ACC_W=16), u3 (LEN=1, ACC_W=16). The multiplier is also checked
// stand-alone over all operand pairs.
// -----------------------------------------------------------------------------
module tb_mac4_dot_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       clear;
  logic       iv   [4];
  logic [3:0] ia   [4];
  logic [3:0] ib   [4];
  logic       ordy [4];

  logic        ir0, ir1, ir2, ir3;
  logic        ov0, ov1, ov2, ov3;
  logic        of0, of1, of2, of3;
  logic [15:0] os0, os2, os3;
  logic [7:0]  os1;

  logic [3:0] ma, mb;
  logic [7:0] mp;

  int checks = 0;
  int errors = 0;

  mac4_dot_accumulator #(.LEN(4), .ACC_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv[0]), .in_ready(ir0),
    .in_a(ia[0]), .in_b(ib[0]), .out_valid(ov0), .out_ready(ordy[0]),
    .out_sum(os0), .out_ovf(of0));
  mac4_dot_accumulator #(.LEN(4), .ACC_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv[1]), .in_ready(ir1),
    .in_a(ia[1]), .in_b(ib[1]), .out_valid(ov1), .out_ready(ordy[1]),
    .out_sum(os1), .out_ovf(of1));
  mac4_dot_accumulator #(.LEN(2), .ACC_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv[2]), .in_ready(ir2),
    .in_a(ia[2]), .in_b(ib[2]), .out_valid(ov2), .out_ready(ordy[2]),
    .out_sum(os2), .out_ovf(of2));
  mac4_dot_accumulator #(.LEN(1), .ACC_W(16)) u3 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv[3]), .in_ready(ir3),
    .in_a(ia[3]), .in_b(ib[3]), .out_valid(ov3), .out_ready(ordy[3]),
    .out_sum(os3), .out_ovf(of3));

  array_multiplier_4x4 u_mul (.i_a(ma), .i_b(mb), .o_prod(mp));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    clear = 1'b0;
    ma = 4'd0;
    mb = 4'd0;
    for (int i = 0; i < 4; i++) begin
      iv[i] = 1'b0; ia[i] = 4'd0; ib[i] = 4'd0; ordy[i] = 1'b0;
    end
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (ov0 !== 1'b0 || os0 !== 16'd0 || of0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_u0: got v=%0b sum=%0d ovf=%0b expected 0 0 0", ov0, os0, of0);
    end
    checks++;
    if (ov1 !== 1'b0 || os1 !== 8'd0 || of1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_u1: got v=%0b sum=%0d ovf=%0b expected 0 0 0", ov1, os1, of1);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    checks++;
    if (ir0 !== 1'b1 || ir3 !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b/%0b expected 1/1", ir0, ir3);
    end
  endtask

  task automatic test_multiplier;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        ma = 4'(a);
        mb = 4'(b);
        #1;
        checks++;
        if (mp !== 8'(a * b)) begin
          errors++;
          $display("FAIL mult %0d*%0d: got %0d expected %0d", a, b, mp, a * b);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic exp_v;
    ordy[0] = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c >= 1) begin
        exp_v = (c == 5) || (c == 9);
        checks++;
        if (ov0 !== exp_v) begin
          errors++;
          $display("FAIL b2b_valid c=%0d: got %0b expected %0b", c, ov0, exp_v);
        end
      end
      if (c == 5) begin
        checks++;
        if (os0 !== 16'd900 || of0 !== 1'b0) begin
          errors++;
          $display("FAIL b2b_sum1: got %0d ovf=%0b expected 900 ovf=0", os0, of0);
        end
      end
      if (c == 9) begin
        checks++;
        if (os0 !== 16'd8 || of0 !== 1'b0) begin
          errors++;
          $display("FAIL b2b_sum2: got %0d ovf=%0b expected 8 ovf=0", os0, of0);
        end
      end
      if (c < 8) begin
        iv[0] = 1'b1;
        ia[0] = (c < 4) ? 4'd15 : 4'd1;
        ib[0] = (c < 4) ? 4'd15 : 4'd2;
      end else begin
        iv[0] = 1'b0;
      end
      #1;
      if (c < 8) begin
        checks++;
        if (ir0 !== 1'b1) begin
          errors++;
          $display("FAIL b2b_in_ready c=%0d: got %0b expected 1", c, ir0);
        end
      end
      tick();
    end
  endtask

  task automatic test_saturation;
    logic exp_v;
    ordy[1] = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c >= 1) begin
        exp_v = (c == 5) || (c == 9);
        checks++;
        if (ov1 !== exp_v) begin
          errors++;
          $display("FAIL sat_valid c=%0d: got %0b expected %0b", c, ov1, exp_v);
        end
      end
      if (c == 5) begin
        checks++;
        if (os1 !== 8'd255 || of1 !== 1'b1) begin
          errors++;
          $display("FAIL sat_sum1: got %0d ovf=%0b expected 255 ovf=1", os1, of1);
        end
      end
      if (c == 9) begin
        checks++;
        if (os1 !== 8'd24 || of1 !== 1'b0) begin
          errors++;
          $display("FAIL sat_sum2: got %0d ovf=%0b expected 24 ovf=0", os1, of1);
        end
      end
      iv[1] = (c < 8);
      case (c)
        0, 1:    begin ia[1] = 4'd15; ib[1] = 4'd15; end
        2:       begin ia[1] = 4'd1;  ib[1] = 4'd1;  end
        3:       begin ia[1] = 4'd0;  ib[1] = 4'd0;  end
        default: begin ia[1] = 4'd2;  ib[1] = 4'd3;  end
      endcase
      #1;
      tick();
    end
    iv[1] = 1'b0;
  endtask

  task automatic test_backpressure;
    int  sent;
    int  delivered;
    logic hs;
    sent = 0;
    delivered = 0;
    for (int c = 0; c < 12; c++) begin
      ordy[2] = (c >= 8);
      iv[2]   = (sent < 5);
      ia[2]   = 4'd1;
      ib[2]   = 4'd1;
      #1;
      hs = iv[2] && ir2;
      if (c >= 3 && c <= 7) begin
        checks++;
        if (ov2 !== 1'b1 || os2 !== 16'd2) begin
          errors++;
          $display("FAIL bp_hold c=%0d: got v=%0b sum=%0d expected v=1 sum=2", c, ov2, os2);
        end
      end
      if (c >= 4 && c <= 7) begin
        checks++;
        if (ir2 !== 1'b0) begin
          errors++;
          $display("FAIL bp_in_ready c=%0d: got %0b expected 0", c, ir2);
        end
      end
      if (ov2 && ordy[2]) begin
        delivered++;
        checks++;
        if (os2 !== 16'd2) begin
          errors++;
          $display("FAIL bp_delivery %0d: got %0d expected 2", delivered, os2);
        end
      end
      @(posedge clk);
      if (hs) sent++;
      #1;
    end
    iv[2] = 1'b0;
    checks++;
    if (delivered != 2 || sent != 5) begin
      errors++;
      $display("FAIL bp_counts: got delivered=%0d sent=%0d expected 2 and 5", delivered, sent);
    end
  endtask

  task automatic test_simultaneous;
    ordy[3] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c >= 2) begin
        checks++;
        if (ov3 !== 1'b1 || os3 !== 16'(3 * (c - 2))) begin
          errors++;
          $display("FAIL simul c=%0d: got v=%0b sum=%0d expected v=1 sum=%0d", c, ov3, os3, 3 * (c - 2));
        end
      end
      iv[3] = (c < 10);
      ia[3] = 4'd3;
      ib[3] = 4'(c);
      #1;
      if (c < 10) begin
        checks++;
        if (ir3 !== 1'b1) begin
          errors++;
          $display("FAIL simul_in_ready c=%0d: got %0b expected 1", c, ir3);
        end
      end
      tick();
    end
    iv[3] = 1'b0;
  endtask

  task automatic test_reset_midgroup;
    logic        seen;
    logic [15:0] got;
    seen = 1'b0;
    got  = 16'd0;
    ordy[0] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      iv[0] = 1'b1; ia[0] = 4'd7; ib[0] = 4'd7;
      tick();
    end
    iv[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov0 !== 1'b0 || os0 !== 16'd0 || of0 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_u0: got v=%0b sum=%0d ovf=%0b expected 0 0 0", ov0, os0, of0);
    end
    checks++;
    if (os3 !== 16'd0) begin
      errors++;
      $display("FAIL midrst_u3: got sum=%0d expected 0", os3);
    end
    tick();
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 12; c++) begin
      iv[0] = (c < 4);
      ia[0] = 4'd1;
      ib[0] = 4'd1;
      tick();
      if (ov0 && !seen) begin
        seen = 1'b1;
        got  = os0;
      end
    end
    iv[0] = 1'b0;
    checks++;
    if (seen !== 1'b1 || got !== 16'd4) begin
      errors++;
      $display("FAIL midrst_group: got seen=%0b sum=%0d expected seen=1 sum=4", seen, got);
    end
  endtask

  task automatic test_clear;
    logic        seen;
    logic [15:0] got;
    seen = 1'b0;
    got  = 16'd0;
    ordy[2] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      iv[2] = 1'b1; ia[2] = 4'd1; ib[2] = 4'd1;
      tick();
    end
    iv[2] = 1'b1; ia[2] = 4'd5; ib[2] = 4'd5;
    clear = 1'b1;
    #1;
    checks++;
    if (ov2 !== 1'b1 || ir2 !== 1'b0) begin
      errors++;
      $display("FAIL clear_pending: got v=%0b in_ready=%0b expected v=1 in_ready=0", ov2, ir2);
    end
    tick();
    clear = 1'b0;
    iv[2] = 1'b0;
    #1;
    checks++;
    if (ov2 !== 1'b0 || ir2 !== 1'b1) begin
      errors++;
      $display("FAIL clear_after: got v=%0b in_ready=%0b expected v=0 in_ready=1", ov2, ir2);
    end
    ordy[2] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      iv[2] = (c < 2);
      ia[2] = 4'd2;
      ib[2] = 4'd2;
      tick();
      if (ov2 && !seen) begin
        seen = 1'b1;
        got  = os2;
      end
    end
    iv[2] = 1'b0;
    checks++;
    if (seen !== 1'b1 || got !== 16'd8 || of2 !== 1'b0) begin
      errors++;
      $display("FAIL clear_group: got seen=%0b sum=%0d ovf=%0b expected seen=1 sum=8 ovf=0", seen, got, of2);
    end
  endtask

  initial begin
    test_reset();
    test_multiplier();
    test_back_to_back();
    test_saturation();
    test_backpressure();
    test_simultaneous();
    test_reset_midgroup();
    test_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
